uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Parametrised UART transmitter with an integrated TX FIFO, for the IO subsystem.
//  Accepts bytes from the CPU/MMIO side at up to one per clock.
//  Frames each byte as: start bit, DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits.
//  Sends frames back-to-back with no idle gap while the FIFO is non-empty.
// PARAMETERS
//  CLKS_PER_BIT  50   clocks per serial bit (>=2); e.g. 50 MHz / 1 MBaud
//  DATA_BITS     8    data bits per frame, 5..8
//  PARITY        0    0 = none, 1 = odd, 2 = even
//  STOP_BITS     1    1 or 2
//  FIFO_DEPTH    16   entries; power of two, >=2
//  AW            $clog2(FIFO_DEPTH) (localparam)
// PORTS
//  i_Clock      in   1          system clock; all logic on rising edge
//  reset_n      in   1          asynchronous reset, active low
//  i_Tx_DV      in   1          push strobe; i_Tx_Byte is written to the FIFO on every clock it is high
//  i_Tx_Byte    in   DATA_BITS  data to push
//  o_Full       out  1          FIFO holds FIFO_DEPTH entries
//  o_Empty      out  1          FIFO holds 0 entries
//  o_Level      out  AW+1       current FIFO occupancy, 0..FIFO_DEPTH
//  o_Overflow   out  1          1-cycle pulse when a push is dropped
//  o_Tx_Active  out  1          a frame is on the line
//  o_Tx_Serial  out  1          serial line, idle high
//  o_Tx_Done    out  1          1-cycle pulse when each frame's last stop bit completes
// BEHAVIOUR
//  Reset (async, reset_n = 0):
//   - FIFO pointers cleared; o_Empty = 1, o_Full = 0, o_Level = 0.
//   - o_Overflow = 0, o_Tx_Active = 0, o_Tx_Done = 0.
//   - o_Tx_Serial = 1 immediately, even mid-frame. The frame is abandoned; FSM goes to IDLE.
//  FIFO:
//   - Read/write pointers are AW+1 bits and wrap naturally.
//   - Level = wr - rd; Full = (Level == FIFO_DEPTH).
//   - Push accepted if not full, or if a pop occurs in the same cycle (full + push + pop: level unchanged).
//   - Push while full with no pop: data dropped, o_Overflow = 1 for that cycle, FIFO unchanged.
//   - Push and pop in the same cycle on a non-full FIFO: level unchanged.
//   - Pop only by FSM (load); no pop when empty.
//  FSM states: IDLE, START, DATA, PARITY, STOP. Bit counter cnt (0..CLKS_PER_BIT-1) and bit index idx.
//   - Load = pop head into shift reg; compute par = ^data (even) or ~^data (odd); cnt = 0; next = START.
//   - IDLE: serial = 1. If !o_Empty, load. Start bit is driven from the edge after the push edge,
//     i.e. first push into an empty idle block -> o_Tx_Serial = 0 one clock after the push is sampled.
//   - START: serial = 0 for CLKS_PER_BIT clocks, then DATA, idx = 0.
//   - DATA: serial = data[idx] for CLKS_PER_BIT clocks each.
//     After idx = DATA_BITS-1 -> PARITY if PARITY != 0, else STOP.
//   - PARITY: serial = par for CLKS_PER_BIT clocks, then STOP.
//   - STOP: serial = 1 for STOP_BITS*CLKS_PER_BIT clocks.
//     At the end: o_Tx_Done pulses 1 cycle.
//     If FIFO is non-empty, load in the same cycle -> START (no gap); else go to IDLE.
//  Frame length = CLKS_PER_BIT*(1 + DATA_BITS + (PARITY != 0) + STOP_BITS) clocks exactly.
//  o_Tx_Active:
//   - 1 from the first START clock until the final STOP clock of the last queued frame.
//   - Stays 1 across back-to-back frames; 0 in IDLE.
//  Output registering: all outputs registered except o_Full/o_Empty/o_Level (combinational from pointers).
//  Pushes during transmission never disturb the frame in progress.
// TESTING
//  1. 8N1, CLKS_PER_BIT=50: push 0xA5 -> serial 0 for 50 clks, then bits 1,0,1,0,0,1,0,1, then 1.
//     Total 500 clks; Done pulses once.
//  2. Push 0x55, 0x0F on consecutive clocks -> two frames with no idle high between the
//     stop bit and the next start bit; Done pulses twice, 500 clks apart; Active stays 1 throughout.
//  3. DEPTH=16: push 17 bytes in 17 clks while FSM idle.
//     First byte pops at clk 1, so all 17 are accepted: Level peaks at 16, Full = 1, Overflow = 0.
//     An 18th push then -> Overflow pulse, Level stays 16.
//  4. PARITY=2, DATA_BITS=7, STOP_BITS=2: push 7'h03 -> parity bit 0, two stop bits; 1100 clks.
//     Same test with PARITY=1 -> parity bit 1.
//  5. Deassert reset_n mid DATA bit 3 -> serial = 1 asynchronously; Level = 0, Active = 0.
//     After release, a new push transmits correctly.
//  6. Full FIFO, push in the exact cycle of a STOP-end pop -> push accepted, no Overflow, Level stays 16.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an integrated TX FIFO.
// Bytes are pushed at up to one per clock; frames are sent back-to-back
// (start, DATA_BITS data LSB first, optional parity, STOP_BITS stop bits)
// for as long as the FIFO holds data.
`timescale 1ns/1ps
module uart_tx_fifo #(
  parameter  int CLKS_PER_BIT = 50,
  parameter  int DATA_BITS    = 8,
  parameter  int PARITY       = 0,   // 0 none, 1 odd, 2 even
  parameter  int STOP_BITS    = 1,
  parameter  int FIFO_DEPTH   = 16,
  localparam int AW           = $clog2(FIFO_DEPTH)
) (
  input  logic                 i_Clock,
  input  logic                 reset_n,
  input  logic                 i_Tx_DV,
  input  logic [DATA_BITS-1:0] i_Tx_Byte,
  output logic                 o_Full,
  output logic                 o_Empty,
  output logic [AW:0]          o_Level,
  output logic                 o_Overflow,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Done
);

  // Stop phase is the longest single state, so the counter is sized for it.
  localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
  localparam int CW        = $clog2(STOP_CLKS);
  localparam int IW        = $clog2(DATA_BITS);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;
  logic [DATA_BITS-1:0] head;
  logic                 pop, push_ok;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par;
  logic                 last_clk, stop_end;

  // Occupancy flags come straight from the pointers so the pusher sees them same-cycle.
  assign o_Level = wr_ptr - rd_ptr;
  assign o_Full  = (o_Level == (AW+1)'(FIFO_DEPTH));
  assign o_Empty = (wr_ptr == rd_ptr);
  assign head    = mem[rd_ptr[AW-1:0]];

  assign last_clk = (cnt == CW'(CLKS_PER_BIT-1));
  assign stop_end = (state == S_STOP) && (cnt == CW'(STOP_CLKS-1));
  // The FSM loads a byte either from idle or at the very end of a frame (no gap).
  assign pop      = !o_Empty && ((state == S_IDLE) || stop_end);
  // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
  assign push_ok  = i_Tx_DV && (!o_Full || pop);

  // FIFO storage; the head is read before this edge's write, so full+push+pop is safe.
  always_ff @(posedge i_Clock) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= i_Tx_Byte;
  end

  // FIFO pointers and the registered drop indicator.
  always_ff @(posedge i_Clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_Overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
      o_Overflow <= i_Tx_DV && !push_ok;
    end
  end

  // Frame sequencer with registered line, active and done outputs.
  always_ff @(posedge i_Clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      par         <= 1'b0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
    end else begin
      o_Tx_Done <= stop_end;
      if (pop) begin
        // Load: start bit goes out from this edge on.
        shreg       <= head;
        par         <= (PARITY == 2) ? ^head : ~^head;
        cnt         <= '0;
        state       <= S_START;
        o_Tx_Serial <= 1'b0;
        o_Tx_Active <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            o_Tx_Serial <= 1'b1;
            o_Tx_Active <= 1'b0;
          end
          S_START: begin
            if (last_clk) begin
              cnt         <= '0;
              idx         <= '0;
              state       <= S_DATA;
              o_Tx_Serial <= shreg[0];
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          S_DATA: begin
            if (last_clk) begin
              cnt <= '0;
              if (idx == IW'(DATA_BITS-1)) begin
                if (PARITY != 0) begin
                  state       <= S_PAR;
                  o_Tx_Serial <= par;
                end else begin
                  state       <= S_STOP;
                  o_Tx_Serial <= 1'b1;
                end
              end else begin
                idx         <= idx + IW'(1);
                shreg       <= shreg >> 1;
                o_Tx_Serial <= shreg[1];
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          S_PAR: begin
            if (last_clk) begin
              cnt         <= '0;
              state       <= S_STOP;
              o_Tx_Serial <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          S_STOP: begin
            if (stop_end) begin
              cnt         <= '0;
              state       <= S_IDLE;
              o_Tx_Active <= 1'b0;
              o_Tx_Serial <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: begin
            state       <= S_IDLE;
            o_Tx_Serial <= 1'b1;
            o_Tx_Active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed frames, a FIFO fill table, reset and
// full-FIFO corner cases, plus random pushes against a frame-level model.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
  localparam int C     = 50;
  localparam int DEPTH = 16;
  localparam int FRAME = C * 10;      // 8N1
  localparam int C4    = 100;
  localparam int FR4   = C4 * 11;     // 7 data, parity, 2 stop

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main 8N1 instance
  logic       dv = 1'b0;
  logic [7:0] byte_in = '0;
  logic       full, empty, ovf, active, serial, done;
  logic [4:0] level;

  // 7E2 / 7O2 instances share one stimulus
  logic       dv7 = 1'b0;
  logic [6:0] byte7 = '0;
  logic       full_e, empty_e, ovf_e, active_e, serial_e, done_e;
  logic       full_o, empty_o, ovf_o, active_o, serial_o, done_o;
  logic [2:0] level_e, level_o;

  uart_tx_fifo #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut (
    .i_Clock(clk), .reset_n(rst_n), .i_Tx_DV(dv), .i_Tx_Byte(byte_in),
    .o_Full(full), .o_Empty(empty), .o_Level(level), .o_Overflow(ovf),
    .o_Tx_Active(active), .o_Tx_Serial(serial), .o_Tx_Done(done));

  uart_tx_fifo #(.CLKS_PER_BIT(C4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_even (
    .i_Clock(clk), .reset_n(rst_n), .i_Tx_DV(dv7), .i_Tx_Byte(byte7),
    .o_Full(full_e), .o_Empty(empty_e), .o_Level(level_e), .o_Overflow(ovf_e),
    .o_Tx_Active(active_e), .o_Tx_Serial(serial_e), .o_Tx_Done(done_e));

  uart_tx_fifo #(.CLKS_PER_BIT(C4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_odd (
    .i_Clock(clk), .reset_n(rst_n), .i_Tx_DV(dv7), .i_Tx_Byte(byte7),
    .o_Full(full_o), .o_Empty(empty_o), .o_Level(level_o), .o_Overflow(ovf_o),
    .o_Tx_Active(active_o), .o_Tx_Serial(serial_o), .o_Tx_Done(done_o));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model (main instance) ----------------
  // Queue of accepted bytes; rem = clocks of the current frame still to be shown.
  logic [7:0] q[$];
  int         rem = 0;
  logic [9:0] cur = '1;
  logic       m_ovf = 1'b0, m_done = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    logic pop;
    if (!rst_n) begin
      q.delete();
      rem    = 0;
      cur    = '1;
      m_ovf  = 1'b0;
      m_done = 1'b0;
    end else begin
      pop    = (rem <= 1) && (q.size() > 0);
      m_done = (rem == 1);
      if (rem > 0) rem--;
      m_ovf  = dv && (q.size() == DEPTH) && !pop;
      if (pop) begin
        cur = {1'b1, q.pop_front(), 1'b0};
        rem = FRAME;
      end
      if (dv && !m_ovf) q.push_back(byte_in);
    end
  end

  // Every cycle: compare all outputs of the main instance to the model.
  always @(negedge clk) begin
    logic [10:0] exp_v, act_v;
    logic        exp_ser;
    if (rst_n) begin
      exp_ser = (rem > 0) ? cur[(FRAME - rem) / C] : 1'b1;
      exp_v   = {exp_ser, rem > 0, m_done, m_ovf, 5'(q.size()), q.size() == DEPTH, q.size() == 0};
      act_v   = {serial, active, done, ovf, level, full, empty};
      chk("model", 32'(act_v), 32'(exp_v));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input logic d, input logic [7:0] b);
    dv = d;
    byte_in = b;
    @(negedge clk);
  endtask

  task automatic do_reset();
    dv = 1'b0;
    dv7 = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Checks one 8N1 frame starting at the current cycle (frame cycle 0).
  task automatic expect_frame(input string name, input logic [7:0] b, input bit first);
    logic [9:0] f;
    int bad;
    f = {1'b1, b, 1'b0};
    bad = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (serial !== f[i / C] || active !== 1'b1 || done !== (i == 0 && !first)) bad++;
      cyc(1'b0, 8'h00);
    end
    chk(name, 32'(bad), 32'd0);
  endtask

  typedef struct {
    logic       dv;
    logic [7:0] b;
    logic [4:0] level;
    logic       full;
    logic       ovf;
  } vec_t;

  vec_t tbl[18];

  initial begin
    logic [10:0] f7e, f7o;
    int bad_e, bad_o;
    logic par_e, par_o;
    int thr[6];

    // Fill from idle: push 0 pops at the next edge, so 17 pushes all fit; the 18th drops.
    for (int k = 0; k < 18; k++) begin
      tbl[k].dv    = 1'b1;
      tbl[k].b     = 8'(k + 1);
      tbl[k].level = (k == 0) ? 5'd1 : ((k >= 16) ? 5'd16 : 5'(k));
      tbl[k].full  = (k >= 16);
      tbl[k].ovf   = (k == 17);
    end

    // ---- reset state ----
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_serial", 32'(serial), 32'd1);
    chk("rst_empty",  32'(empty),  32'd1);
    chk("rst_level",  32'(level),  32'd0);
    chk("rst_active", 32'(active), 32'd0);
    #2 rst_n = 1'b1;

    // ---- single 8N1 frame 0xA5 ----
    cyc(1'b1, 8'hA5);
    chk("t1_level_push", 32'(level), 32'd1);
    chk("t1_idle_high",  32'(serial), 32'd1);
    cyc(1'b0, 8'h00);
    chk("t1_start_low",  32'(serial), 32'd0);
    chk("t1_popped",     32'(level), 32'd0);
    expect_frame("t1_frame_a5", 8'hA5, 1'b1);
    chk("t1_done",   32'(done),   32'd1);
    chk("t1_active", 32'(active), 32'd0);
    chk("t1_serial", 32'(serial), 32'd1);
    cyc(1'b0, 8'h00);
    chk("t1_done_pulse", 32'(done), 32'd0);

    // ---- back-to-back 0x55, 0x0F ----
    do_reset();
    cyc(1'b1, 8'h55);
    cyc(1'b1, 8'h0F);
    expect_frame("t2_frame_55", 8'h55, 1'b1);
    expect_frame("t2_frame_0f", 8'h0F, 1'b0);
    chk("t2_done2",  32'(done),   32'd1);
    chk("t2_active", 32'(active), 32'd0);

    // ---- fill table ----
    do_reset();
    for (int k = 0; k < 18; k++) begin
      cyc(tbl[k].dv, tbl[k].b);
      chk($sformatf("t3_level_%0d", k), 32'(level), 32'(tbl[k].level));
      chk($sformatf("t3_full_%0d", k),  32'(full),  32'(tbl[k].full));
      chk($sformatf("t3_ovf_%0d", k),   32'(ovf),   32'(tbl[k].ovf));
    end
    cyc(1'b0, 8'h00);
    chk("t3_ovf_clear", 32'(ovf), 32'd0);
    chk("t3_level_hold", 32'(level), 32'd16);

    // ---- full FIFO, push exactly on the stop-end pop ----
    do_reset();
    cyc(1'b1, 8'h11);                                   // edge 0
    for (int k = 0; k < 16; k++) cyc(1'b1, 8'(8'h20 + k)); // edges 1..16
    chk("t6_full", 32'(full), 32'd1);
    repeat (FRAME - 16) cyc(1'b0, 8'h00);               // edges 17..500
    cyc(1'b1, 8'hEE);                                   // edge 501: stop end
    chk("t6_level", 32'(level),  32'd16);
    chk("t6_novf",  32'(ovf),    32'd0);
    chk("t6_done",  32'(done),   32'd1);
    chk("t6_start", 32'(serial), 32'd0);
    chk("t6_act",   32'(active), 32'd1);
    cyc(1'b1, 8'hEF);
    chk("t6_ovf_after", 32'(ovf), 32'd1);
    chk("t6_level_after", 32'(level), 32'd16);

    // ---- async reset mid data bit 3 ----
    do_reset();
    cyc(1'b1, 8'h96);
    cyc(1'b1, 8'h01);
    cyc(1'b1, 8'h02);                  // now frame cycle 1, level 2
    repeat (224) cyc(1'b0, 8'h00);     // frame cycle 225: data bit 3
    chk("t5_bit3", 32'(serial), 32'd0);
    chk("t5_lvl_pre", 32'(level), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_serial", 32'(serial), 32'd1);
    chk("t5_level",  32'(level),  32'd0);
    chk("t5_active", 32'(active), 32'd0);
    chk("t5_empty",  32'(empty),  32'd1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    cyc(1'b1, 8'h3C);
    cyc(1'b0, 8'h00);
    expect_frame("t5_frame_3c", 8'h3C, 1'b1);
    chk("t5_done", 32'(done), 32'd1);

    // ---- 7E2 and 7O2, byte 7'h03 ----
    do_reset();
    dv7 = 1'b1;
    byte7 = 7'h03;
    @(negedge clk);
    dv7 = 1'b0;
    @(negedge clk);
    f7e = {2'b11, 1'b0, 7'h03, 1'b0};
    f7o = {2'b11, 1'b1, 7'h03, 1'b0};
    bad_e = 0;
    bad_o = 0;
    par_e = 1'bx;
    par_o = 1'bx;
    for (int i = 0; i < FR4; i++) begin
      if (i == 8 * C4 + C4 / 2) begin
        par_e = serial_e;
        par_o = serial_o;
      end
      if (serial_e !== f7e[i / C4] || active_e !== 1'b1 || done_e !== 1'b0) bad_e++;
      if (serial_o !== f7o[i / C4] || active_o !== 1'b1 || done_o !== 1'b0) bad_o++;
      @(negedge clk);
    end
    chk("t4_even_frame", 32'(bad_e), 32'd0);
    chk("t4_odd_frame",  32'(bad_o), 32'd0);
    chk("t4_even_par",   32'(par_e), 32'd0);
    chk("t4_odd_par",    32'(par_o), 32'd1);
    chk("t4_even_done",  32'(done_e), 32'd1);
    chk("t4_odd_done",   32'(done_o), 32'd1);
    chk("t4_even_idle",  32'(active_e), 32'd0);

    // ---- random pushes against the model ----
    do_reset();
    thr = '{2, 5, 20, 400, 900, 3};
    for (int r = 0; r < 6; r++) begin
      for (int n = 0; n < 3000; n++) begin
        cyc(1'($urandom_range(0, 999) < thr[r]), 8'($urandom));
      end
    end
    cyc(1'b0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
